// File: rtl/rom_fetch_pkg.sv
// Shared defaults and the fetch-buffer entry type for the ROM fetch stage.
package rom_fetch_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 16;
  localparam int unsigned ADDR_WIDTH_DEF = 8;

  // One buffered fetch: the word and the address it came from.
  typedef struct packed {
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } fetch_entry_t;

endpackage

// File: rtl/rom_fetch_unit_fifo.sv
// Small synchronous FIFO for the fetch buffer: push/pop/flush, flush wins.
module fetch_fifo #(
  parameter  int unsigned WIDTH = 24,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned CW    = $clog2(DEPTH + 1),
  localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_q;
  logic [PW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem[rd_q];

  // A push into a full buffer is accepted only when the head leaves the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Pointer, count and storage update; flush empties without touching storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q] <= data_i;
        wr_q      <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rom_fetch_unit.sv
// Fetch stage: owns the PC, reads the async ROM, buffers {addr,data} for decode.
module rom_fetch_unit
  import rom_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned WORDS      = 5,
  parameter int unsigned RESET_ADDR = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  input  logic                  redirect_i,
  input  logic [ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                  instr_valid_o,
  input  logic                  instr_ready_i,
  output logic [DATA_WIDTH-1:0] instr_data_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  output logic                  fault_o
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  // One extra bit so WORDS == 2**ADDR_WIDTH keeps every PC in range.
  localparam logic [ADDR_WIDTH:0] WORDS_LIM = (ADDR_WIDTH + 1)'(WORDS);

  logic [ADDR_WIDTH-1:0]            pc_q;
  logic                             fault_q;
  logic                             in_range;
  logic                             pop;
  logic                             push;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_in;
  logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_out;
  logic [CW-1:0]                    fifo_count;
  logic                             fifo_full;
  logic                             fifo_empty;

  assign in_range = ({1'b0, pc_q} < WORDS_LIM);
  assign pop      = instr_valid_o & instr_ready_i;
  assign push     = ~redirect_i & ~fault_q & in_range & ((fifo_count < DEPTH_C) | pop);
  assign fifo_in  = {pc_q, rom_data_i};

  assign rom_addr_o                   = pc_q;
  assign fault_o                      = fault_q;
  assign instr_valid_o                = ~fifo_empty;
  assign {instr_addr_o, instr_data_o} = fifo_out;

  // PC advances on every accepted fetch; redirect reloads it and clears the fault.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q    <= ADDR_WIDTH'(RESET_ADDR);
      fault_q <= 1'b0;
    end else if (redirect_i) begin
      pc_q    <= redirect_addr_i;
      fault_q <= 1'b0;
    end else begin
      if (push) pc_q <= pc_q + 1'b1;
      if (!in_range) fault_q <= 1'b1;
    end
  end

  // Buffer full flag and occupancy must always agree.
  always_ff @(posedge clk_i) begin
    if (rst_ni) assert (fifo_full == (fifo_count == DEPTH_C));
  end

  fetch_fifo #(
    .WIDTH (ADDR_WIDTH + DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_i),
    .data_i  (fifo_in),
    .data_o  (fifo_out),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_rom_fetch_unit.sv
// Bench for rom_fetch_unit: directed scenarios plus randomized traffic vs a queue model.
module tb_rom_fetch_unit;
  import rom_fetch_pkg::*;

  localparam int NWORDS = 5;
  localparam int FDEPTH = 2;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        valid;
  logic        ready;
  logic [15:0] idata;
  logic [7:0]  iaddr;
  logic        fault;

  int vectors;
  int miscompares;

  // Reference state: buffered entries, PC and fault flag.
  fetch_entry_t mq[$];
  logic [7:0]   mpc;
  logic         mfault;

  function automatic logic [15:0] rom_word(input logic [7:0] a);
    if (a < NWORDS) return 16'h1111 * (16'(a) + 16'd1);
    return 16'hBAD0;
  endfunction

  always_comb rom_data = rom_word(rom_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rom_fetch_unit #(
    .DATA_WIDTH (16),
    .ADDR_WIDTH (8),
    .WORDS      (NWORDS),
    .RESET_ADDR (0),
    .FIFO_DEPTH (FDEPTH)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .rom_addr_o      (rom_addr),
    .rom_data_i      (rom_data),
    .redirect_i      (redirect),
    .redirect_addr_i (redirect_addr),
    .instr_valid_o   (valid),
    .instr_ready_i   (ready),
    .instr_data_o    (idata),
    .instr_addr_o    (iaddr),
    .fault_o         (fault)
  );

  task automatic model_reset();
    mq.delete();
    mpc    = 8'd0;
    mfault = 1'b0;
  endtask

  // One clock: advance the model with the inputs held across the edge, then settle at negedge.
  task automatic tick();
    bit pop, push, inr;
    fetch_entry_t e;
    @(posedge clk);
    if (rst_n) begin
      pop = (mq.size() != 0) && ready;
      inr = (mpc < NWORDS);
      if (redirect) begin
        mq.delete();
        mpc    = redirect_addr;
        mfault = 1'b0;
      end else begin
        push = !mfault && inr && ((mq.size() < FDEPTH) || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
          e.addr = mpc;
          e.data = rom_word(mpc);
          mq.push_back(e);
          mpc = mpc + 8'd1;
        end
        if (!inr) mfault = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic rdy);
    rst_n    = 1'b0;
    redirect = 1'b0;
    ready    = rdy;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; redirect = 1'b0; redirect_addr = 8'd0; ready = 1'b0;
    model_reset();
    #3;
    vectors++;
    if ({valid, fault, rom_addr, iaddr, idata} !== {1'b0, 1'b0, 8'd0, 8'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got v=%b f=%b pc=%h a=%h d=%h expected all zero",
               valid, fault, rom_addr, iaddr, idata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    vectors++;
    if ({valid, rom_addr} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("FAIL reset_release: got v=%b pc=%h expected v=0 pc=00", valid, rom_addr);
    end
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    for (int c = 1; c <= 5; c++) begin
      tick();
      vectors++;
      if ({valid, fault, iaddr, idata} !== {1'b1, 1'b0, 8'(c - 1), 16'h1111 * 16'(c)}) begin
        miscompares++;
        $display("FAIL stream_c%0d: got v=%b f=%b a=%h d=%h expected v=1 f=0 a=%h d=%h",
                 c, valid, fault, iaddr, idata, 8'(c - 1), 16'h1111 * 16'(c));
      end
    end
    tick();
    vectors++;
    if ({valid, fault, rom_addr} !== {1'b0, 1'b1, 8'd5}) begin
      miscompares++;
      $display("FAIL stream_end: got v=%b f=%b pc=%h expected v=0 f=1 pc=05", valid, fault, rom_addr);
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      vectors++;
      if ({valid, iaddr, idata} !== {1'b1, 8'd0, 16'h1111}) begin
        miscompares++;
        $display("FAIL stall_c%0d: got v=%b a=%h d=%h expected v=1 a=00 d=1111", c, valid, iaddr, idata);
      end
    end
    vectors++;
    if (rom_addr !== 8'd2) begin
      miscompares++;
      $display("FAIL stall_pc: got %h expected 02", rom_addr);
    end
    ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      vectors++;
      if ({valid, iaddr, idata} !== {1'b1, 8'(k), 16'h1111 * 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL drain_k%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                 k, valid, iaddr, idata, 8'(k), 16'h1111 * 16'(k + 1));
      end
      tick();
    end
  endtask

  task automatic test_redirect_flush();
    apply_reset(1'b0);
    repeat (2) tick();
    vectors++;
    if ({valid, iaddr, mq.size() == 2} !== {1'b1, 8'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL flush_setup: got v=%b a=%h expected v=1 a=00 with two buffered", valid, iaddr);
    end
    redirect = 1'b1; redirect_addr = 8'd3;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({valid, fault, rom_addr} !== {1'b0, 1'b0, 8'd3}) begin
      miscompares++;
      $display("FAIL flush_empty: got v=%b f=%b pc=%h expected v=0 f=0 pc=03", valid, fault, rom_addr);
    end
    tick();
    vectors++;
    if ({valid, iaddr, idata} !== {1'b1, 8'd3, 16'h4444}) begin
      miscompares++;
      $display("FAIL flush_target: got v=%b a=%h d=%h expected v=1 a=03 d=4444", valid, iaddr, idata);
    end
  endtask

  task automatic test_fault_redirect();
    apply_reset(1'b1);
    repeat (6) tick();
    vectors++;
    if (fault !== 1'b1) begin
      miscompares++;
      $display("FAIL fault_set: got %b expected 1", fault);
    end
    redirect = 1'b1; redirect_addr = 8'd1;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({fault, valid} !== {1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL fault_clear: got f=%b v=%b expected f=0 v=0", fault, valid);
    end
    for (int k = 1; k <= 2; k++) begin
      tick();
      vectors++;
      if ({valid, iaddr, idata} !== {1'b1, 8'(k), 16'h1111 * 16'(k + 1)}) begin
        miscompares++;
        $display("FAIL fault_resume_%0d: got v=%b a=%h d=%h expected v=1 a=%h d=%h",
                 k, valid, iaddr, idata, 8'(k), 16'h1111 * 16'(k + 1));
      end
    end
  endtask

  task automatic test_redirect_oob();
    ready = 1'b1;
    redirect = 1'b1; redirect_addr = 8'd7;
    tick();
    redirect = 1'b0;
    vectors++;
    if ({fault, valid, rom_addr} !== {1'b0, 1'b0, 8'd7}) begin
      miscompares++;
      $display("FAIL oob_first: got f=%b v=%b pc=%h expected f=0 v=0 pc=07", fault, valid, rom_addr);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      vectors++;
      if ({fault, valid, rom_addr} !== {1'b1, 1'b0, 8'd7}) begin
        miscompares++;
        $display("FAIL oob_hold_%0d: got f=%b v=%b pc=%h expected f=1 v=0 pc=07", k, fault, valid, rom_addr);
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b0);
    redirect = 1'b1; redirect_addr = 8'd4;
    tick();
    redirect = 1'b0;
    repeat (2) tick();
    vectors++;
    if ({valid, fault, iaddr, idata} !== {1'b1, 1'b1, 8'd4, 16'h5555}) begin
      miscompares++;
      $display("FAIL areset_setup: got v=%b f=%b a=%h d=%h expected v=1 f=1 a=04 d=5555",
               valid, fault, iaddr, idata);
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({valid, fault, rom_addr, iaddr, idata} !== {1'b0, 1'b0, 8'd0, 8'd0, 16'd0}) begin
      miscompares++;
      $display("FAIL areset_drop: got v=%b f=%b pc=%h a=%h d=%h expected all zero",
               valid, fault, rom_addr, iaddr, idata);
    end
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    tick();
    vectors++;
    if ({valid, iaddr, idata} !== {1'b1, 8'd0, 16'h1111}) begin
      miscompares++;
      $display("FAIL areset_restart: got v=%b a=%h d=%h expected v=1 a=00 d=1111", valid, iaddr, idata);
    end
  endtask

  task automatic test_random();
    apply_reset(1'b0);
    for (int n = 0; n < 400; n++) begin
      ready         = ($urandom_range(0, 3) != 0);
      redirect      = ($urandom_range(0, 15) == 0);
      redirect_addr = 8'($urandom_range(0, 7));
      vectors++;
      if ({valid, fault, rom_addr} !== {mq.size() != 0, mfault, mpc}) begin
        miscompares++;
        $display("FAIL rand_ctl_%0d: got v=%b f=%b pc=%h expected v=%b f=%b pc=%h",
                 n, valid, fault, rom_addr, mq.size() != 0, mfault, mpc);
      end
      if (mq.size() != 0) begin
        vectors++;
        if ({iaddr, idata} !== mq[0]) begin
          miscompares++;
          $display("FAIL rand_head_%0d: got a=%h d=%h expected a=%h d=%h",
                   n, iaddr, idata, mq[0].addr, mq[0].data);
        end
      end
      tick();
    end
    redirect = 1'b0;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_fault_redirect();
    test_redirect_oob();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
